fft_stage_sequencer: RTL and testbench

- Iterative scheduler that time-multiplexes one shared butterfly stage across all NPOINT radix-2 stages of a 2**NPOINT-point FFT frame.
- Accepts a frame, applies optional bit-reversal, and issues the frame to the butterfly NPOINT times with the stage index on bf_step. Results are written back in place, and the finished spectrum is presented downstream.
- Sits between the frame source and a single butterfly instance plus its external twiddle ROM, which is addressed by bf_step.

---
 rtl/fft_stage_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Iterative radix-2 FFT stage scheduler: loads a frame, runs it NPOINT times through one shared butterfly, presents the result.
// Latency: 1 load cycle + per stage (issue handshake + butterfly latency + 1 capture cycle).
// Backpressure: valid/busy on every port; valids and data hold until taken; one frame in flight.
module fft_stage_sequencer #(
  parameter int WIDTH     = 16,
  parameter int NPOINT    = 3,
  parameter int BITREV_IN = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_valid,
  output logic                          din_busy,
  input  logic [WIDTH*(2**NPOINT)-1:0]  din_real,
  input  logic [WIDTH*(2**NPOINT)-1:0]  din_imag,
  output logic                          bf_din_valid,
  input  logic                          bf_din_busy,
  output logic [WIDTH*(2**NPOINT)-1:0]  bf_din_real,
  output logic [WIDTH*(2**NPOINT)-1:0]  bf_din_imag,
  output logic [NPOINT-1:0]             bf_step,
  input  logic                          bf_dout_valid,
  output logic                          bf_dout_busy,
  input  logic [WIDTH*(2**NPOINT)-1:0]  bf_dout_real,
  input  logic [WIDTH*(2**NPOINT)-1:0]  bf_dout_imag,
  output logic                          dout_valid,
  input  logic                          dout_busy,
  output logic [WIDTH*(2**NPOINT)-1:0]  dout_real,
  output logic [WIDTH*(2**NPOINT)-1:0]  dout_imag,
  output logic                          seq_err
);

  localparam int NS     = 2**NPOINT;
  localparam int FW     = WIDTH * NS;
  localparam int LAST_I = NPOINT - 1;
  localparam logic [NPOINT-1:0] LAST_STAGE = LAST_I[NPOINT-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NPOINT-1:0] stage_q, stage_d;
  logic [FW-1:0]     buf_real_q, buf_imag_q;
  logic [FW-1:0]     load_real, load_imag;
  logic              seq_err_q;
  logic              din_xfer, bf_in_xfer, bf_out_xfer, dout_xfer;

  // Reverse the low NPOINT bits of a sample index.
  function automatic int bitrev(input int idx);
    int r;
    r = 0;
    for (int b = 0; b < NPOINT; b++) begin
      if (((idx >> b) & 1) == 1) r = r | (1 << (NPOINT - 1 - b));
    end
    return r;
  endfunction

  // Load permutation is pure wiring: buffer slot g takes input sample SRC.
  for (genvar g = 0; g < NS; g++) begin : g_load
    localparam int SRC = (BITREV_IN != 0) ? bitrev(g) : g;
    assign load_real[g*WIDTH +: WIDTH] = din_real[SRC*WIDTH +: WIDTH];
    assign load_imag[g*WIDTH +: WIDTH] = din_imag[SRC*WIDTH +: WIDTH];
  end

  // Handshake completions; each is qualified by the state that owns the port.
  assign din_xfer    = (state_q == S_IDLE)  && din_valid;
  assign bf_in_xfer  = (state_q == S_ISSUE) && !bf_din_busy;
  assign bf_out_xfer = (state_q == S_WAIT)  && bf_dout_valid;
  assign dout_xfer   = (state_q == S_DONE)  && !dout_busy;

  // Next-state and stage counter; the counter never wraps because the last stage exits to DONE.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (din_xfer) begin
          stage_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bf_in_xfer) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bf_out_xfer) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (dout_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    din_busy     = 1'b1;
    bf_din_valid = 1'b0;
    bf_dout_busy = 1'b1;
    dout_valid   = 1'b0;
    case (state_q)
      S_IDLE:  din_busy     = 1'b0;
      S_ISSUE: bf_din_valid = 1'b1;
      S_WAIT:  bf_dout_busy = 1'b0;
      S_DONE:  dout_valid   = 1'b1;
      default: din_busy     = 1'b1;
    endcase
  end

  // State and stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  // In-place frame buffer: written on frame load and on each accepted butterfly result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_real_q <= '0;
      buf_imag_q <= '0;
    end else if (din_xfer) begin
      buf_real_q <= load_real;
      buf_imag_q <= load_imag;
    end else if (bf_out_xfer) begin
      buf_real_q <= bf_dout_real;
      buf_imag_q <= bf_dout_imag;
    end
  end

  // Sticky flag for a butterfly result arriving when none is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err_q <= 1'b0;
    end else if (bf_dout_valid && (state_q != S_WAIT)) begin
      seq_err_q <= 1'b1;
    end
  end

  assign bf_step     = stage_q;
  assign bf_din_real = buf_real_q;
  assign bf_din_imag = buf_imag_q;
  assign dout_real   = buf_real_q;
  assign dout_imag   = buf_imag_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer: bit-reversed and natural-order instances run in lockstep.
// An echo butterfly (adds 16*(step+1) real, step+1 imag, one cycle latency) closes the loop.
// Results are checked against a permutation-plus-offset model of the whole frame.
module tb_fft_stage_sequencer;

  localparam int W  = 16;
  localparam int NP = 3;
  localparam int NS = 8;
  localparam int FW = W * NS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid, bf_din_busy, bf_dout_valid, dout_busy;
  logic [FW-1:0] din_real, din_imag;

  logic          r_din_busy, r_bf_din_valid, r_bf_dout_busy, r_dout_valid, r_seq_err;
  logic [NP-1:0] r_bf_step;
  logic [FW-1:0] r_bf_din_real, r_bf_din_imag, r_bf_dout_real, r_bf_dout_imag, r_dout_real, r_dout_imag;
  logic          n_din_busy, n_bf_din_valid, n_bf_dout_busy, n_dout_valid, n_seq_err;
  logic [NP-1:0] n_bf_step;
  logic [FW-1:0] n_bf_din_real, n_bf_din_imag, n_bf_dout_real, n_bf_dout_imag, n_dout_real, n_dout_imag;

  int checks = 0;
  int errors = 0;
  int stall_left = 0;
  bit rand_bp = 1'b0;
  bit exp_err = 1'b0;
  logic [FW-1:0] cur_re, cur_im;
  int step_q[$];

  fft_stage_sequencer #(.WIDTH(W), .NPOINT(NP), .BITREV_IN(1)) u_rev (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_busy(r_din_busy), .din_real(din_real), .din_imag(din_imag),
    .bf_din_valid(r_bf_din_valid), .bf_din_busy(bf_din_busy),
    .bf_din_real(r_bf_din_real), .bf_din_imag(r_bf_din_imag), .bf_step(r_bf_step),
    .bf_dout_valid(bf_dout_valid), .bf_dout_busy(r_bf_dout_busy),
    .bf_dout_real(r_bf_dout_real), .bf_dout_imag(r_bf_dout_imag),
    .dout_valid(r_dout_valid), .dout_busy(dout_busy),
    .dout_real(r_dout_real), .dout_imag(r_dout_imag), .seq_err(r_seq_err)
  );

  fft_stage_sequencer #(.WIDTH(W), .NPOINT(NP), .BITREV_IN(0)) u_nat (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_busy(n_din_busy), .din_real(din_real), .din_imag(din_imag),
    .bf_din_valid(n_bf_din_valid), .bf_din_busy(bf_din_busy),
    .bf_din_real(n_bf_din_real), .bf_din_imag(n_bf_din_imag), .bf_step(n_bf_step),
    .bf_dout_valid(bf_dout_valid), .bf_dout_busy(n_bf_dout_busy),
    .bf_dout_real(n_bf_dout_real), .bf_dout_imag(n_bf_dout_imag),
    .dout_valid(n_dout_valid), .dout_busy(dout_busy),
    .dout_real(n_dout_real), .dout_imag(n_dout_imag), .seq_err(n_seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic int rev3(input int i);
    return (i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4) % 2;
  endfunction

  // Buffer contents after s stages: loaded order plus the accumulated echo offsets.
  function automatic logic [FW-1:0] exp_stage(input logic [FW-1:0] d, input int s, input bit brev, input int unit);
    logic [FW-1:0] r;
    logic [W-1:0]  off;
    int            src;
    int            tot;
    tot = unit * s * (s + 1) / 2;
    off = tot[W-1:0];
    for (int i = 0; i < NS; i++) begin
      src = brev ? rev3(i) : i;
      r[i*W +: W] = d[src*W +: W] + off;
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] add_each(input logic [FW-1:0] d, input int k);
    logic [FW-1:0] r;
    logic [W-1:0]  kk;
    kk = k[W-1:0];
    for (int i = 0; i < NS; i++) r[i*W +: W] = d[i*W +: W] + kk;
    return r;
  endfunction

  // One clock: apply backpressure, check any butterfly issue, advance the echo butterfly.
  task automatic tick();
    bit            in_x, out_x;
    logic [NP-1:0] st;
    logic [FW-1:0] rr, ri, nr, ni;
    if (stall_left > 0 && r_bf_din_valid && r_bf_step == 3'd1) begin
      bf_din_busy = 1'b1;
      stall_left--;
      chk("stall_valid", FW'(r_bf_din_valid), FW'(1));
      chk("stall_step", FW'(r_bf_step), FW'(1));
      chk("stall_real", r_bf_din_real, exp_stage(cur_re, 1, 1'b1, 16));
      chk("stall_imag", r_bf_din_imag, exp_stage(cur_im, 1, 1'b1, 1));
    end else begin
      bf_din_busy = rand_bp ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    in_x  = r_bf_din_valid && !bf_din_busy;
    out_x = bf_dout_valid && !r_bf_dout_busy;
    st = r_bf_step;
    rr = r_bf_din_real; ri = r_bf_din_imag;
    nr = n_bf_din_real; ni = n_bf_din_imag;
    if (in_x) begin
      step_q.push_back(int'(st));
      chk("bf_in_rev_real", rr, exp_stage(cur_re, int'(st), 1'b1, 16));
      chk("bf_in_rev_imag", ri, exp_stage(cur_im, int'(st), 1'b1, 1));
      chk("bf_in_nat_real", nr, exp_stage(cur_re, int'(st), 1'b0, 16));
      chk("bf_in_nat_step", FW'(n_bf_step), FW'(st));
    end
    @(posedge clk);
    #1;
    if (out_x) bf_dout_valid = 1'b0;
    if (in_x) begin
      bf_dout_valid  = 1'b1;
      r_bf_dout_real = add_each(rr, 16 * (int'(st) + 1));
      r_bf_dout_imag = add_each(ri, int'(st) + 1);
      n_bf_dout_real = add_each(nr, 16 * (int'(st) + 1));
      n_bf_dout_imag = add_each(ni, int'(st) + 1);
    end
  endtask

  task automatic run_frame(input logic [FW-1:0] re, input logic [FW-1:0] im, input int dstall,
                           input bit preload, input logic [FW-1:0] nre, input logic [FW-1:0] nim,
                           input bit chk_lat, input bit fast, input bit chk_ord);
    int  n;
    int  cyc;
    bit  xfer;
    logic [FW-1:0] ord_rev, ord_nat;
    ord_rev = {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0};
    ord_nat = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    cur_re = re; cur_im = im;
    din_real = re; din_imag = im; din_valid = 1'b1;
    step_q.delete();
    n = 0;
    xfer = 1'b0;
    while (!xfer && n < 100) begin
      xfer = din_valid && !r_din_busy;
      tick();
      n++;
    end
    din_valid = 1'b0;
    if (!xfer) timeout("load");
    if (fast) chk("load_cycles", FW'(n), FW'(1));
    if (chk_ord) begin
      chk("order_rev", r_bf_din_real, ord_rev);
      chk("order_nat", n_bf_din_real, ord_nat);
    end
    // cycle 1 is the one right after the din transfer edge
    cyc = 1;
    while (!r_dout_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!r_dout_valid) timeout("dout_valid");
    if (chk_lat) chk("latency", FW'(cyc), FW'(7));
    chk("step_count", FW'(step_q.size()), FW'(3));
    for (int i = 0; i < step_q.size() && i < 3; i++) chk("step_seq", FW'(step_q[i]), FW'(i));
    chk("nat_dout_valid", FW'(n_dout_valid), FW'(1));
    chk("rev_dout_real", r_dout_real, exp_stage(re, 3, 1'b1, 16));
    chk("rev_dout_imag", r_dout_imag, exp_stage(im, 3, 1'b1, 1));
    chk("nat_dout_real", n_dout_real, exp_stage(re, 3, 1'b0, 16));
    chk("nat_dout_imag", n_dout_imag, exp_stage(im, 3, 1'b0, 1));
    chk("seq_err", FW'(r_seq_err), FW'(exp_err));
    dout_busy = 1'b1;
    if (preload) begin
      din_real = nre; din_imag = nim; din_valid = 1'b1;
    end
    for (int k = 0; k < dstall; k++) begin
      tick();
      chk("dstall_valid", FW'(r_dout_valid), FW'(1));
      chk("dstall_real", r_dout_real, exp_stage(re, 3, 1'b1, 16));
      chk("dstall_din_busy", FW'(r_din_busy), FW'(1));
    end
    dout_busy = 1'b0;
    tick();
    chk("post_dout_valid", FW'(r_dout_valid), FW'(0));
    chk("post_din_busy", FW'(r_din_busy), FW'(0));
  endtask

  initial begin
    logic [FW-1:0] ramp, ramp_im, save, rre, rim;
    int n;
    din_valid = 1'b0; bf_din_busy = 1'b0; bf_dout_valid = 1'b0; dout_busy = 1'b0;
    din_real = '0; din_imag = '0;
    r_bf_dout_real = '0; r_bf_dout_imag = '0; n_bf_dout_real = '0; n_bf_dout_imag = '0;
    for (int i = 0; i < NS; i++) begin
      ramp[i*W +: W]    = 16'(i);
      ramp_im[i*W +: W] = 16'(3 * i + 100);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_busy", FW'(r_din_busy), FW'(0));
    chk("rst_bf_din_valid", FW'(r_bf_din_valid), FW'(0));
    chk("rst_bf_dout_busy", FW'(r_bf_dout_busy), FW'(1));
    chk("rst_dout_valid", FW'(r_dout_valid), FW'(0));
    chk("rst_seq_err", FW'(r_seq_err), FW'(0));
    chk("rst_bf_step", FW'(r_bf_step), FW'(0));
    chk("rst_dout_real", r_dout_real, FW'(0));
    rst_n = 1'b1;
    tick();

    // Ramp frame with the next frame queued behind it, then the queued frame back-to-back.
    run_frame(ramp, ramp_im, 0, 1'b1, ramp, ramp_im, 1'b1, 1'b0, 1'b1);
    run_frame(ramp, ramp_im, 0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);

    // Butterfly input stall on stage 1 and output stall in DONE with the next frame waiting.
    stall_left = 5;
    rre = {$urandom, $urandom, $urandom, $urandom};
    rim = {$urandom, $urandom, $urandom, $urandom};
    run_frame(rre, rim, 4, 1'b1, ramp, ramp_im, 1'b0, 1'b0, 1'b0);
    chk("stall_consumed", FW'(stall_left), FW'(0));
    run_frame(ramp, ramp_im, 0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);

    // Reset while waiting on a butterfly result.
    cur_re = rre; cur_im = rim;
    din_real = rre; din_imag = rim; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n = 0;
    while (r_bf_dout_busy && n < 50) begin
      tick();
      n++;
    end
    if (r_bf_dout_busy) timeout("reach_wait");
    rst_n = 1'b0;
    #1;
    bf_dout_valid = 1'b0;
    chk("mid_rst_din_busy", FW'(r_din_busy), FW'(0));
    chk("mid_rst_bf_din_valid", FW'(r_bf_din_valid), FW'(0));
    chk("mid_rst_bf_dout_busy", FW'(r_bf_dout_busy), FW'(1));
    chk("mid_rst_dout_valid", FW'(r_dout_valid), FW'(0));
    chk("mid_rst_seq_err", FW'(r_seq_err), FW'(0));
    chk("mid_rst_bf_step", FW'(r_bf_step), FW'(0));
    chk("mid_rst_bf_din_real", r_bf_din_real, FW'(0));
    chk("mid_rst_dout_imag", n_dout_imag, FW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("after_rst_dout_valid", FW'(r_dout_valid), FW'(0));
    chk("after_rst_din_busy", FW'(r_din_busy), FW'(0));

    // Spurious butterfly result while idle.
    save = r_bf_din_real;
    bf_dout_valid = 1'b1;
    r_bf_dout_real = '1; r_bf_dout_imag = '1; n_bf_dout_real = '1; n_bf_dout_imag = '1;
    tick();
    bf_dout_valid = 1'b0;
    exp_err = 1'b1;
    chk("spur_seq_err_rev", FW'(r_seq_err), FW'(1));
    chk("spur_seq_err_nat", FW'(n_seq_err), FW'(1));
    chk("spur_buffer", r_bf_din_real, save);
    run_frame(ramp, ramp_im, 1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Random data with random backpressure on both sides.
    rand_bp = 1'b1;
    for (int f = 0; f < 20; f++) begin
      rre = {$urandom, $urandom, $urandom, $urandom};
      rim = {$urandom, $urandom, $urandom, $urandom};
      run_frame(rre, rim, int'($urandom_range(0, 3)), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
    chk("final_seq_err", FW'(r_seq_err), FW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
